// File: rtl/frame_gen.sv
// frame_gen: frame stream transmitter; one valid/sop/eop frame per start, then an idle gap.
// Optional build macro FRAME_GEN_CONTINUOUS_EN adds i_repeat for gapless back-to-back frames.
module frame_gen #(
  parameter int LEN_W = 8,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_abort,
`ifdef FRAME_GEN_CONTINUOUS_EN
  input  logic             i_repeat,
`endif
  output logic             o_valid,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frameCount
);

  // state | meaning
  // IDLE  | waiting for i_start with a non-zero length
  // SEND  | emitting one beat per cycle, beatCnt is the beat on the outputs
  // GAP   | idle cycles after eop, gapCnt counts down to 1
  typedef enum logic [1:0] {IDLE, SEND, GAP} stateE;

  stateE            state, stateNext;
  logic [LEN_W-1:0] beatCnt, beatNext, lenQ, lenNext;
  logic [GAP_W-1:0] gapQ, gapNext, gapCnt, gapCntNext;
  logic [CNT_W-1:0] countNext;
  logic             validNext, sopNext, eopNext, busyNext, load;
`ifdef FRAME_GEN_CONTINUOUS_EN
  logic             abortedQ, abortedNext;
`endif

  always_comb begin
    stateNext  = state;
    beatNext   = beatCnt;
    lenNext    = lenQ;
    gapNext    = gapQ;
    gapCntNext = gapCnt;
    countNext  = o_frameCount;
    validNext  = 1'b0;
    sopNext    = 1'b0;
    eopNext    = 1'b0;
    load       = 1'b0;
`ifdef FRAME_GEN_CONTINUOUS_EN
    abortedNext = abortedQ;
`endif
    case (state)
      IDLE: load = i_start && (i_len != '0);
      SEND: begin
        if (o_eop) begin
          countNext = o_frameCount + CNT_W'(1);
          if (gapQ != '0) begin
            stateNext  = GAP;
            gapCntNext = gapQ;
          end else begin
            stateNext = IDLE;
`ifdef FRAME_GEN_CONTINUOUS_EN
            load = i_repeat && (i_len != '0) && !abortedQ;
`endif
          end
        end else begin
          beatNext  = beatCnt + LEN_W'(1);
          validNext = 1'b1;
          eopNext   = (beatCnt + LEN_W'(1) == lenQ) || i_abort;
`ifdef FRAME_GEN_CONTINUOUS_EN
          if (i_abort) abortedNext = 1'b1;
`endif
        end
      end
      GAP: begin
        if (gapCnt == GAP_W'(1)) begin
          stateNext = IDLE;
`ifdef FRAME_GEN_CONTINUOUS_EN
          load = i_repeat && (i_len != '0) && !abortedQ;
`endif
        end else begin
          gapCntNext = gapCnt - GAP_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    // a load overrides whatever the state branch decided, including a repeat
    if (load) begin
      stateNext = SEND;
      lenNext   = i_len;
      gapNext   = i_gap;
      beatNext  = LEN_W'(1);
      validNext = 1'b1;
      sopNext   = 1'b1;
      eopNext   = (i_len == LEN_W'(1));
`ifdef FRAME_GEN_CONTINUOUS_EN
      abortedNext = 1'b0;
`endif
    end
    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= IDLE;
      beatCnt      <= '0;
      lenQ         <= '0;
      gapQ         <= '0;
      gapCnt       <= '0;
      o_valid      <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_busy       <= 1'b0;
      o_frameCount <= '0;
`ifdef FRAME_GEN_CONTINUOUS_EN
      abortedQ     <= 1'b0;
`endif
    end else begin
      state        <= stateNext;
      beatCnt      <= beatNext;
      lenQ         <= lenNext;
      gapQ         <= gapNext;
      gapCnt       <= gapCntNext;
      o_valid      <= validNext;
      o_sop        <= sopNext;
      o_eop        <= eopNext;
      o_busy       <= busyNext;
      o_frameCount <= countNext;
`ifdef FRAME_GEN_CONTINUOUS_EN
      abortedQ     <= abortedNext;
`endif
    end
  end

endmodule

// File: doc/frame_gen.md
Name: frame_gen

Overview:
- Frame stream transmitter. Produces valid/sop/eop beat sequences that downstream frame-checking logic consumes.
- Driven by a start pulse plus length and gap configuration. Emits one well-formed frame per start, then an inter-frame gap.
- Keeps a running count of completed frames. Used as a stimulus source and as an on-chip traffic generator on the frame interface.

Parameters:
- LEN_W, 8, width of frame length input; max frame = 2^LEN_W-1 beats
- GAP_W, 4, width of inter-frame gap input, in idle cycles
- CNT_W, 16, width of completed-frame counter

Ports:
- i_clk  input  1  clock, rising edge
- i_arst_n  input  1  asynchronous active-low reset
- i_start  input  1  request one frame; sampled in IDLE only
- i_len  input  LEN_W  frame length in beats; sampled with i_start
- i_gap  input  GAP_W  idle cycles after eop; sampled with i_start
- i_abort  input  1  terminate current frame early
- o_valid  output  1  beat valid
- o_sop  output  1  first beat of frame
- o_eop  output  1  last beat of frame
- o_busy  output  1  high in SEND or GAP
- o_frameCount  output  CNT_W  completed frames, wraps

Behaviour:
- One clock, i_clk. Reset i_arst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-frame drops the frame immediately: no eop, no count.
- All outputs are registered. Latency is 1 cycle from i_start sampled to first beat (o_valid=o_sop=1).
- States:
  - IDLE: if i_start=1 and i_len!=0, latch len/gap, beat counter=1, go to SEND. If i_start=1 and i_len=0, ignore and stay IDLE.
  - SEND: one beat per cycle, o_valid=1 every cycle.
    - o_sop=1 only on beat 1.
    - o_eop=1 only on beat len.
    - len=1 gives sop and eop on the same beat.
  - Exit SEND: after the eop beat, go to GAP if latched gap!=0, else IDLE.
  - GAP: o_valid/o_sop/o_eop=0 for exactly gap cycles, then IDLE. A start may be accepted in the first IDLE cycle.
- i_start in SEND or GAP is ignored. It is not queued.
- Abort:
  - i_abort=1 sampled in SEND when the current beat is not eop: the next beat is the final beat with o_eop=1, then normal gap handling. A frame aborted on beat 1 gives sop beat then eop beat (2 beats).
  - Abort coinciding with the natural eop beat has no extra effect.
  - Abort in IDLE/GAP is ignored.
- Simultaneous i_start and i_abort in IDLE: start wins, abort is ignored.
- o_frameCount increments by 1 the cycle after each eop beat (aborted frames included). Wraps 2^CNT_W-1 -> 0.
- Protocol guarantees:
  - sop/eop never high without valid.
  - No sop between sop and its eop.
  - o_valid=0 outside frames.
  - At least gap idle cycles between eop and the next sop, plus 1 IDLE cycle in non-continuous mode.
- o_busy=1 in SEND and GAP, else 0.

Optional Feature:
- Macro: FRAME_GEN_CONTINUOUS_EN
- Enabled:
  - Adds input port i_repeat (1 bit).
  - On the last GAP cycle (or on the eop cycle when gap=0), if i_repeat=1 and i_len!=0: resample i_len/i_gap and start the next frame on the following cycle. sop directly follows the gap, with no IDLE cycle; when gap=0, frames are back-to-back (eop then sop on consecutive cycles).
  - i_abort also suppresses the repeat for the aborted frame, returning to IDLE after its gap.
- Disabled: no i_repeat port; always return to IDLE after the gap, as above.

Test Plan:
- Reset, then i_start with len=4, gap=2 -> valid for cycles 1-4, sop at 1, eop at 4, valid=0 for 2 cycles, o_frameCount=1, o_busy falls after gap.
- len=1, gap=0 -> single beat with sop=eop=valid=1; a new start accepted next IDLE cycle yields 1 idle cycle between frames.
- len=10, abort sampled during beat 3 -> beat 4 has eop=1, exactly 4 beats, count increments; abort on natural eop beat -> unchanged 10-beat frame.
- i_start with len=0 -> no output, count unchanged. i_start pulses during SEND/GAP -> ignored, single frame only.
- Assert i_arst_n=0 mid-frame at beat 2 -> outputs 0 immediately, count unchanged, IDLE after release. CNT_W=2: 5 frames -> count reads 1.
- FRAME_GEN_CONTINUOUS_EN, i_repeat=1, len=3, gap=0 -> back-to-back frames (eop then sop next cycle); drop i_repeat -> IDLE after the current frame.
